elevator_request_scheduler: RTL

Upstream stage of the elevator controller. Latches hall/cab call buttons into a pending-call register and picks the next target floor using a SCAN (directional sweep) policy. Drives one target at a time on `request_floor`, then waits for the controller's `complete` at that floor. Runs a door-dwell timer before selecting the next target.

---
 rtl/elevator_request_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/elevator_request_scheduler.sv
// SCAN-policy request scheduler: latches floor calls, dispatches one target at a
// time to the car controller, and holds the door open for a dwell period on arrival.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no pending calls, waiting for a button press
//   SELECT   | one cycle: pick next target from pending using the sweep direction
//   DISPATCH | target driven on request_floor, waiting for arrival at target
//   DOOR     | door open, dwell timer counting down to terminal count
module elevator_request_scheduler #(
  parameter int FW           = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<FW)-1:0]    call_btn,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  complete,
  input  logic                  timer_alert,
  input  logic                  weight_alert,
  output logic [FW-1:0]         request_floor,
  output logic                  req_valid,
  output logic                  door_open,
  output logic [(1<<FW)-1:0]    pending,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int FLOORS = 1 << FW;
  localparam int CW     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_DISPATCH = 2'd2,
    S_DOOR     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [FLOORS-1:0]   pending_nxt;
  logic [FLOORS-1:0]   set_mask;
  logic [FLOORS-1:0]   clr_mask;
  logic [FW-1:0]       request_floor_nxt;
  logic                dir_up_nxt;
  logic [CW-1:0]       dwell_cnt, dwell_cnt_nxt;

  logic                above_hit, below_hit;
  logic [FW-1:0]       above_idx, below_idx;
  logic                service;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    above_hit = 1'b0;
    above_idx = '0;
    below_hit = 1'b0;
    below_idx = '0;
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (f > int'(cur_floor))) begin
        above_hit = 1'b1;
        above_idx = FW'(f);
      end
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (pending[f] && (f < int'(cur_floor))) begin
        below_hit = 1'b1;
        below_idx = FW'(f);
      end
    end
  end

  // Position match filters out a complete still asserted from the previous target.
  assign service = complete && (cur_floor == request_floor) && !timer_alert && !weight_alert;

  always_comb begin
    state_nxt         = state;
    request_floor_nxt = request_floor;
    dir_up_nxt        = dir_up;
    dwell_cnt_nxt     = dwell_cnt;
    set_mask          = call_btn;
    clr_mask          = '0;

    case (state)
      S_IDLE: begin
        if (pending != '0) state_nxt = S_SELECT;
      end

      S_SELECT: begin
        if (pending == '0) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DISPATCH;
          if (pending[cur_floor]) begin
            request_floor_nxt = cur_floor;
          end else if (dir_up) begin
            if (above_hit) begin
              request_floor_nxt = above_idx;
            end else begin
              dir_up_nxt        = 1'b0;
              request_floor_nxt = below_idx;
            end
          end else begin
            if (below_hit) begin
              request_floor_nxt = below_idx;
            end else begin
              dir_up_nxt        = 1'b1;
              request_floor_nxt = above_idx;
            end
          end
        end
      end

      S_DISPATCH: begin
        if (service) begin
          state_nxt                = S_DOOR;
          clr_mask[request_floor]  = 1'b1;
          set_mask[request_floor]  = 1'b0;
          dwell_cnt_nxt            = DWELL_LOAD;
        end
      end

      S_DOOR: begin
        // A press of the floor being served only holds the door; it is never latched.
        set_mask[request_floor] = 1'b0;
        if (weight_alert || call_btn[request_floor]) begin
          dwell_cnt_nxt = DWELL_LOAD;
        end else if (dwell_cnt == '0) begin
          state_nxt = (pending != '0) ? S_SELECT : S_IDLE;
        end else begin
          dwell_cnt_nxt = dwell_cnt - 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    pending_nxt = (pending | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pending       <= '0;
      request_floor <= '0;
      dir_up        <= 1'b1;
      dwell_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      request_floor <= request_floor_nxt;
      dir_up        <= dir_up_nxt;
      dwell_cnt     <= dwell_cnt_nxt;
    end
  end

  assign req_valid = (state == S_DISPATCH);
  assign door_open = (state == S_DOOR);
  assign busy      = (state != S_IDLE);

endmodule
